// File: rtl/campbell_uart_multi.sv
// campbell_uart_multi: multi-channel Campbell (mean-square) estimator that
// sends each window's per-channel results as a byte frame over a UART.
// Optional feature macro: CAMPBELL_PULSE_CNT_EN adds NPC 16-bit pulse
// counters, whose values are sent in the frame just before the terminator.
module campbell_uart_multi #(
  parameter int unsigned NCH      = 2,
  parameter int unsigned DW       = 12,
  parameter int unsigned MIDSCALE = 2048,
  parameter int unsigned LOG2N    = 13,
  parameter int unsigned SPERIOD  = 100,
  parameter int unsigned OUTW     = 24,
  parameter int unsigned NPC      = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH*DW-1:0] data,
  input  logic              done,
  output logic              start,
  output logic              TxD_start,
  output logic [7:0]        TxD_data,
  input  logic              TxD_busy,
`ifdef CAMPBELL_PULSE_CNT_EN
  input  logic [NPC-1:0]    Pulse_in,
`endif
  output logic              overrun
);

  localparam int unsigned SQW = 2*DW + 2;
  localparam int unsigned AW  = SQW + LOG2N;
  localparam int unsigned TW  = (SPERIOD > 1) ? $clog2(SPERIOD) : 1;
`ifdef CAMPBELL_PULSE_CNT_EN
  localparam int unsigned PC_BYTES = 2*NPC;
`else
  // No pulse bytes in the frame when the counters are absent.
  localparam int unsigned PC_BYTES = 0*NPC;
`endif
  localparam int unsigned NBYTES = NCH*OUTW/8 + PC_BYTES + 1;
  localparam int unsigned FW     = NBYTES*8;
  localparam int unsigned BW     = $clog2(NBYTES + 1);
  localparam logic [DW:0] MID_V  = (DW+1)'(MIDSCALE);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_LOAD     = 3'd1;
  localparam logic [2:0] S_SEND     = 3'd2;
  localparam logic [2:0] S_WAITBUSY = 3'd3;
  localparam logic [2:0] S_WAITIDLE = 3'd4;

  logic [TW-1:0]       timer;
  logic                done_q;
  logic                cap;
  logic                v1, v2;
  logic [LOG2N-1:0]    scnt;
  logic [DW:0]         sub  [NCH];
  logic [SQW-1:0]      sq   [NCH];
  logic [AW-1:0]       acc  [NCH];
  logic [OUTW-1:0]     res  [NCH];
  logic signed [SQW-1:0] sx [NCH];
  logic [AW-1:0]       sum  [NCH];
  logic [AW-1:0]       avg  [NCH];
  logic [OUTW-1:0]     sat  [NCH];
  logic                latch_ev;
  logic                accept;
  logic                pending;
  logic [2:0]          state;
  logic [FW-1:0]       frame_sr;
  logic [FW-1:0]       frame_w;
  logic [BW-1:0]       bidx;
  logic [3:0]          tmo;
  logic                busy_s1, busy_s;
  logic                last_byte;
  logic                going_idle;

  assign cap        = done & ~done_q;
  assign latch_ev   = v2 && (scnt == '1);
  assign last_byte  = (bidx == BW'(NBYTES - 1));
  assign going_idle = (state == S_WAITIDLE) && !busy_s && last_byte;
  // A result landing on the cycle the FSM returns to IDLE is still accepted.
  assign accept     = latch_ev && ((state == S_IDLE) || going_idle);

  assign TxD_start  = (state == S_SEND);
  assign TxD_data   = TxD_start ? frame_sr[FW-1 -: 8] : 8'h00;

  // Conversion timer; start is registered so it is low in reset and first
  // rises one cycle after reset release, for timer values 0 and 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer <= '0;
      start <= 1'b0;
    end else begin
      start <= (timer <= TW'(1));
      timer <= (timer == TW'(SPERIOD - 1)) ? '0 : timer + 1'b1;
    end
  end

  // Square and saturated window-average for each channel.
  always_comb begin
    for (int unsigned k = 0; k < NCH; k++) begin
      sx[k]  = SQW'($signed(sub[k]));
      sum[k] = acc[k] + AW'(sq[k]);
      avg[k] = sum[k] >> LOG2N;
      sat[k] = (avg[k] > AW'({OUTW{1'b1}})) ? '1 : avg[k][OUTW-1:0];
    end
  end

  // Capture (S1: offset), square (S2) and accumulate (S3) pipeline.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_q <= 1'b0;
      v1     <= 1'b0;
      v2     <= 1'b0;
      scnt   <= '0;
      for (int unsigned k = 0; k < NCH; k++) begin
        sub[k] <= '0;
        sq[k]  <= '0;
        acc[k] <= '0;
      end
    end else begin
      done_q <= done;
      v1     <= cap;
      v2     <= v1;
      for (int unsigned k = 0; k < NCH; k++) begin
        if (cap) sub[k] <= {1'b0, data[k*DW +: DW]} - MID_V;
        if (v1)  sq[k]  <= SQW'(sx[k] * sx[k]);
        if (v2)  acc[k] <= latch_ev ? '0 : sum[k];
      end
      if (v2) scnt <= scnt + 1'b1;
    end
  end

  // Result hand-off to the UART side and sticky overrun flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= 1'b0;
      overrun <= 1'b0;
      for (int unsigned k = 0; k < NCH; k++) res[k] <= '0;
    end else begin
      if (accept) begin
        pending <= 1'b1;
        for (int unsigned k = 0; k < NCH; k++) res[k] <= sat[k];
      end else if (state == S_LOAD) begin
        pending <= 1'b0;
      end
      if (latch_ev && !accept) overrun <= 1'b1;
    end
  end

`ifdef CAMPBELL_PULSE_CNT_EN
  logic [NPC-1:0] p_s1, p_s2, p_s3;
  logic [NPC-1:0] p_edge;
  logic [15:0]    pc      [NPC];
  logic [15:0]    pc_snap [NPC];

  assign p_edge = p_s2 & ~p_s3;

  // Synchronised, edge-detected, saturating pulse counters, restarted at
  // every result latch (an edge in that cycle belongs to the new window).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_s1 <= '0;
      p_s2 <= '0;
      p_s3 <= '0;
      for (int unsigned j = 0; j < NPC; j++) begin
        pc[j]      <= '0;
        pc_snap[j] <= '0;
      end
    end else begin
      p_s1 <= Pulse_in;
      p_s2 <= p_s1;
      p_s3 <= p_s2;
      for (int unsigned j = 0; j < NPC; j++) begin
        if (accept) pc_snap[j] <= pc[j];
        if (latch_ev)
          pc[j] <= {15'd0, p_edge[j]};
        else if (p_edge[j] && (pc[j] != 16'hFFFF))
          pc[j] <= pc[j] + 16'd1;
      end
    end
  end
`endif

  // Frame image: channel results MSB first, optional pulse counts, 0xFF.
  always_comb begin
    frame_w = '0;
    for (int unsigned k = 0; k < NCH; k++)
      frame_w[FW-1-k*OUTW -: OUTW] = res[k];
`ifdef CAMPBELL_PULSE_CNT_EN
    for (int unsigned j = 0; j < NPC; j++)
      frame_w[8+(NPC-1-j)*16 +: 16] = pc_snap[j];
`endif
    frame_w[7:0] = 8'hFF;
  end

  // Two-flop synchroniser for the UART busy flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_s1 <= 1'b0;
      busy_s  <= 1'b0;
    end else begin
      busy_s1 <= TxD_busy;
      busy_s  <= busy_s1;
    end
  end

  // Byte sender FSM; the frame is a shift register, byte 0 at the top.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      frame_sr <= '0;
      bidx     <= '0;
      tmo      <= '0;
    end else begin
      case (state)
        S_IDLE: if (pending) state <= S_LOAD;
        S_LOAD: begin
          frame_sr <= frame_w;
          bidx     <= '0;
          state    <= S_SEND;
        end
        S_SEND: begin
          tmo   <= '0;
          state <= S_WAITBUSY;
        end
        S_WAITBUSY: begin
          if (busy_s || (tmo == 4'd15)) state <= S_WAITIDLE;
          else                          tmo   <= tmo + 4'd1;
        end
        S_WAITIDLE: begin
          if (!busy_s) begin
            if (last_byte) begin
              state <= S_IDLE;
            end else begin
              frame_sr <= {frame_sr[FW-9:0], 8'h00};
              bidx     <= bidx + 1'b1;
              state    <= S_SEND;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_campbell_uart_multi.sv
`timescale 1ns/1ps
module tb_campbell_uart_multi;
  localparam int unsigned NCH     = 2;
  localparam int unsigned DW      = 12;
  localparam int unsigned LOG2N   = 4;
  localparam int unsigned OUTW    = 24;
  localparam int unsigned NPC     = 2;
  localparam int unsigned SPERIOD = 20;
  localparam int unsigned NSAMP   = 1 << LOG2N;
`ifdef CAMPBELL_PULSE_CNT_EN
  localparam int unsigned NBYTES  = NCH*OUTW/8 + 2*NPC + 1;
`else
  localparam int unsigned NBYTES  = NCH*OUTW/8 + 1;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NCH*DW-1:0] data = '0;
  logic              done = 1'b0;
  logic              start;
  logic              TxD_start;
  logic [7:0]        TxD_data;
  logic              TxD_busy;
  logic              overrun;
`ifdef CAMPBELL_PULSE_CNT_EN
  logic [NPC-1:0]    pulse = '0;
`endif

  logic        force_busy = 1'b0;
  int          busy_cnt = 0;
  logic [7:0]  rx_q [$];
  logic [7:0]  exp_q [$];
  int unsigned smp [NCH][NSAMP];
  int unsigned pcnt [NPC];
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  campbell_uart_multi #(
    .NCH(NCH), .DW(DW), .MIDSCALE(2048), .LOG2N(LOG2N),
    .SPERIOD(SPERIOD), .OUTW(OUTW), .NPC(NPC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .data(data),
    .done(done),
    .start(start),
    .TxD_start(TxD_start),
    .TxD_data(TxD_data),
    .TxD_busy(TxD_busy),
`ifdef CAMPBELL_PULSE_CNT_EN
    .Pulse_in(pulse),
`endif
    .overrun(overrun)
  );

  // UART model: busy for 20 cycles after each strobe, or forced high.
  assign TxD_busy = force_busy || (busy_cnt != 0);
  always @(posedge clk) begin
    if (TxD_start)         busy_cnt <= 20;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end

  always @(negedge clk) if (TxD_start) rx_q.push_back(TxD_data);

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: mean of squared deviation from midscale, clipped to OUTW bits.
  task automatic model_frame();
    exp_q.delete();
    for (int k = 0; k < NCH; k++) begin
      longint s = 0;
      longint r;
      for (int i = 0; i < NSAMP; i++) begin
        longint d = longint'(smp[k][i]) - 2048;
        s += d * d;
      end
      r = s / NSAMP;
      if (r > 64'hFFFFFF) r = 64'hFFFFFF;
      for (int b = OUTW/8 - 1; b >= 0; b--) exp_q.push_back(8'((r >> (8*b)) & 255));
    end
`ifdef CAMPBELL_PULSE_CNT_EN
    for (int j = 0; j < NPC; j++) begin
      exp_q.push_back(8'(pcnt[j] >> 8));
      exp_q.push_back(8'(pcnt[j] & 255));
    end
`endif
    exp_q.push_back(8'hFF);
  endtask

  task automatic set_const(input int unsigned a, input int unsigned b, input int unsigned p0);
    for (int i = 0; i < NSAMP; i++) begin
      smp[0][i] = a;
      smp[1][i] = b;
    end
    pcnt[0] = p0;
    for (int j = 1; j < NPC; j++) pcnt[j] = 0;
  endtask

  task automatic set_rand();
    for (int k = 0; k < NCH; k++)
      for (int i = 0; i < NSAMP; i++) smp[k][i] = $urandom_range(0, 4095);
    for (int j = 0; j < NPC; j++) pcnt[j] = $urandom_range(0, 5);
  endtask

  task automatic send_window();
    for (int i = 0; i < NSAMP; i++) begin
      @(negedge clk);
      for (int k = 0; k < NCH; k++) data[k*DW +: DW] = DW'(smp[k][i]);
      done = 1'b1;
`ifdef CAMPBELL_PULSE_CNT_EN
      for (int j = 0; j < NPC; j++) pulse[j] = (i < int'(pcnt[j]));
`endif
      @(negedge clk);
      done = 1'b0;
      repeat (2) @(negedge clk);
`ifdef CAMPBELL_PULSE_CNT_EN
      pulse = '0;
`endif
      repeat (3) @(negedge clk);
    end
  endtask

  task automatic wait_bytes(input int n, input int budget);
    for (int c = 0; c < budget; c++) begin
      if (rx_q.size() >= n) break;
      @(negedge clk);
      #1;
    end
  endtask

  task automatic recv_check(input string tag);
    wait_bytes(NBYTES, 3000);
    check_eq({tag, "_nbytes"}, 64'(rx_q.size()), 64'(NBYTES));
    for (int i = 0; i < NBYTES; i++)
      check_eq($sformatf("%s_b%0d", tag, i),
               (i < rx_q.size()) ? 64'(rx_q[i]) : 64'h100, 64'(exp_q[i]));
    repeat (30) @(negedge clk);
    rx_q.delete();
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_eq("rst_start", 64'(start), 64'd0);
    check_eq("rst_txstart", 64'(TxD_start), 64'd0);
    check_eq("rst_txdata", 64'(TxD_data), 64'd0);
    check_eq("rst_overrun", 64'(overrun), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("start_first", 64'(start), 64'd1);
    repeat (2) @(negedge clk);
    check_eq("start_low", 64'(start), 64'd0);

    set_const(2048, 2048, 3); model_frame(); send_window(); recv_check("mid");
    set_const(2058, 1048, 0); model_frame(); send_window(); recv_check("dev");
    set_const(0, 4095, 1);    model_frame(); send_window(); recv_check("ext");
    for (int w = 0; w < 4; w++) begin
      set_rand(); model_frame(); send_window(); recv_check($sformatf("rnd%0d", w));
    end
    check_eq("ovr_clear", 64'(overrun), 64'd0);

    // Busy stuck high across two windows.
    force_busy = 1'b1;
    set_rand(); model_frame(); send_window();
    wait_bytes(1, 500);
    set_rand(); send_window();
    repeat (40) @(negedge clk);
    check_eq("stall_nbytes", 64'(rx_q.size()), 64'd1);
    check_eq("ovr_set", 64'(overrun), 64'd1);
    force_busy = 1'b0;
    recv_check("inflight");
    check_eq("ovr_sticky", 64'(overrun), 64'd1);

    // Reset in the middle of a frame.
    set_rand(); model_frame(); send_window();
    wait_bytes(4, 3000);
    check_eq("pre_rst_nbytes", 64'(rx_q.size()), 64'd4);
    rst = 1'b1;
    #1;
    check_eq("mid_rst_txstart", 64'(TxD_start), 64'd0);
    check_eq("mid_rst_txdata", 64'(TxD_data), 64'd0);
    check_eq("mid_rst_overrun", 64'(overrun), 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    rx_q.delete();
    repeat (100) @(negedge clk);
    check_eq("no_resume", 64'(rx_q.size()), 64'd0);
    set_rand(); model_frame(); send_window(); recv_check("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
